// File: rtl/mem_write.sv
// mem_write: AXI write-channel initiator for the memory subsystem.
// Takes one write request at a time and issues it as a single INCR burst on
// AW/W, then waits for the B response. o_write_process/o_write_address stay
// up for the whole transaction so the read side can hold off same-line reads.
// Optional feature: define MEM_WRITE_STRB_EN to drive the latched per-beat
// byte strobes on wstrb; otherwise every beat is a full-word write.

package mem_write_pkg;

  typedef struct packed {
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi_w_req;

  typedef struct packed {
    logic       awready;
    logic       wready;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic       bvalid;
  } axi_w_resp;

endpackage

module mem_write
  import mem_write_pkg::*;
#(
  parameter int unsigned   LINE_BYTE_OFFSET = 6,
  parameter logic [3:0]    WRITE_ID         = 4'b0000,
  localparam int unsigned  LINE_WORDS       = 2 ** (LINE_BYTE_OFFSET - 2),
  localparam int unsigned  LW               = LINE_BYTE_OFFSET - 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [31:0]               i_req_addr,
  input  logic [LW-1:0]             i_req_len,
  input  logic [2:0]                i_req_size,
  input  logic [32*LINE_WORDS-1:0]  i_req_data,
  input  logic [4*LINE_WORDS-1:0]   i_req_strb,
  output logic                      o_write_process,
  output logic [31:0]               o_write_address,
  output logic                      o_done,
  output logic                      o_err,
  output axi_w_req                  axi_bus_req,
  input  axi_w_resp                 axi_bus_resp
);

  typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

  state_t                   state;
  logic                     aw_pend;
  logic                     w_pend;
  logic [LW-1:0]            beat;
  logic [31:0]              addr_q;
  logic [LW-1:0]            len_q;
  logic [2:0]               size_q;
  logic [32*LINE_WORDS-1:0] data_q;
  logic                     done_q;
  logic                     err_q;

  logic                     wlast;
  logic                     last_hs;
  logic                     aw_pend_nx;
  logic                     w_pend_nx;

`ifdef MEM_WRITE_STRB_EN
  logic [4*LINE_WORDS-1:0]  strb_q;
  logic                     unused_ok;
  assign unused_ok = ^axi_bus_resp.bid;
`else
  logic                     unused_ok;
  assign unused_ok = ^{i_req_strb, axi_bus_resp.bid};
`endif

  // Handshake bookkeeping for the current BURST cycle.
  assign wlast      = (beat == len_q);
  assign last_hs    = w_pend & axi_bus_resp.wready & wlast;
  assign aw_pend_nx = aw_pend & ~axi_bus_resp.awready;
  assign w_pend_nx  = w_pend & ~last_hs;

  // Transaction FSM: latch the request, run AW/W independently, await B.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the line buffer is reset too, so wdata reads 0 out of reset instead
  // of stale or unknown data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      beat    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      data_q  <= '0;
`ifdef MEM_WRITE_STRB_EN
      strb_q  <= '0;
`endif
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            addr_q  <= i_req_addr;
            len_q   <= i_req_len;
            size_q  <= i_req_size;
            data_q  <= i_req_data;
`ifdef MEM_WRITE_STRB_EN
            strb_q  <= i_req_strb;
`endif
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
            beat    <= '0;
            state   <= BURST;
          end
        end
        BURST: begin
          aw_pend <= aw_pend_nx;
          w_pend  <= w_pend_nx;
          // The counter stops on the final beat, so len = max never wraps.
          if (w_pend && axi_bus_resp.wready && !wlast) begin
            beat <= beat + 1'b1;
          end
          if (!aw_pend_nx && !w_pend_nx) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (axi_bus_resp.bvalid) begin
            state  <= IDLE;
            done_q <= 1'b1;
            err_q  <= (axi_bus_resp.bresp != 2'b00);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req_ready     = (state == IDLE);
  assign o_write_process = (state != IDLE);
  assign o_write_address = addr_q;
  assign o_done          = done_q;
  assign o_err           = err_q;

  // AXI request fields: constants plus latched request and pending flags.
  // NOTE: the whole struct gets a default first so no field can infer a latch.
  always_comb begin
    axi_bus_req         = '0;
    axi_bus_req.awid    = WRITE_ID;
    axi_bus_req.awaddr  = addr_q;
    axi_bus_req.awlen   = 8'(len_q);
    axi_bus_req.awsize  = size_q;
    axi_bus_req.awburst = 2'b01;
    axi_bus_req.awvalid = aw_pend;
    axi_bus_req.wid     = WRITE_ID;
    axi_bus_req.wdata   = data_q[{beat, 5'd0} +: 32];
`ifdef MEM_WRITE_STRB_EN
    axi_bus_req.wstrb   = strb_q[{beat, 2'd0} +: 4];
`else
    axi_bus_req.wstrb   = 4'b1111;
`endif
    axi_bus_req.wlast   = wlast;
    axi_bus_req.wvalid  = w_pend;
    axi_bus_req.bready  = (state == RESP);
  end

endmodule
